// File: rtl/audio_codec_emulator.sv
// rtl/audio_codec_emulator.sv - I2S master-mode codec model: drives BCLK/LRCK/ADCDAT, samples DACDAT
// One 64-bit frame = two 32-bit slots; each slot carries a DATA_W sample MSB first after a one-bit delay.
module audio_codec_emulator #(
  parameter int DATA_W   = 16,
  parameter int BCLK_DIV = 4
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic [DATA_W-1:0] tx_left,
  input  logic [DATA_W-1:0] tx_right,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_left,
  output logic [DATA_W-1:0] rx_right,
  output logic              rx_valid,
  output logic              audio_BCLK,
  output logic              audio_ADCLRCK,
  output logic              audio_DACLRCK,
  output logic              audio_ADCDAT,
  input  logic              audio_DACDAT,
  output logic              underrun
);
  localparam int DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);

  logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
  logic              bclk_q, bclk_d;
  logic [5:0]        bit_cnt_q, bit_cnt_d;
  logic              lrck_q, lrck_d;
  logic              adcdat_q, adcdat_d;
  logic [DATA_W-1:0] buf_l_q, buf_l_d, buf_r_q, buf_r_d;
  logic              full_q, full_d;
  logic              tx_ready_q, tx_ready_d;
  logic [DATA_W-1:0] tx_l_q, tx_l_d, tx_r_q, tx_r_d;
  logic              underrun_q, underrun_d;
  logic [DATA_W-1:0] rx_sh_q, rx_sh_d, rx_lhold_q, rx_lhold_d;
  logic              rx_done_q, rx_done_d;
  logic [DATA_W-1:0] rx_left_q, rx_left_d, rx_right_q, rx_right_d;
  logic              rx_valid_q, rx_valid_d;

  logic              div_tc, fall_tog, rise_tog, frame_start, accept, in_rx, slot_end;
  logic [4:0]        k_nxt, k_cur;
  logic [DATA_W-1:0] adc_word;

  always_comb begin
    div_tc      = (div_cnt_q == DIV_LAST);
    fall_tog    = div_tc & bclk_q;
    rise_tog    = div_tc & ~bclk_q;
    frame_start = fall_tog && (bit_cnt_q == 6'd63);
    accept      = tx_valid & tx_ready_q;

    div_cnt_d = div_tc ? '0 : div_cnt_q + DIV_W'(1);
    bclk_d    = div_tc ? ~bclk_q : bclk_q;
    bit_cnt_d = fall_tog ? bit_cnt_q + 6'd1 : bit_cnt_q;
    lrck_d    = fall_tog ? bit_cnt_d[5] : lrck_q;
    k_nxt     = bit_cnt_d[4:0];
    k_cur     = bit_cnt_q[4:0];

    buf_l_d    = buf_l_q;
    buf_r_d    = buf_r_q;
    full_d     = full_q;
    tx_l_d     = tx_l_q;
    tx_r_d     = tx_r_q;
    underrun_d = 1'b0;
    if (frame_start) begin
      tx_l_d     = full_q ? buf_l_q : '0;
      tx_r_d     = full_q ? buf_r_q : '0;
      underrun_d = ~full_q;
      full_d     = 1'b0;
    end
    // A pair arriving on the frame-start cycle lands in the now-empty buffer for the next frame.
    if (accept) begin
      buf_l_d = tx_left;
      buf_r_d = tx_right;
      full_d  = 1'b1;
    end
    tx_ready_d = ~full_d;

    adc_word = '0;
    adcdat_d = adcdat_q;
    if (fall_tog) begin
      adcdat_d = 1'b0;
      if (k_nxt != 5'd0 && int'(k_nxt) <= DATA_W) begin
        adc_word = (bit_cnt_d[5] ? tx_r_q : tx_l_q) >> (5'(DATA_W) - k_nxt);
        adcdat_d = adc_word[0];
      end
    end

    in_rx      = rise_tog && (k_cur != 5'd0) && (int'(k_cur) <= DATA_W);
    slot_end   = in_rx && (int'(k_cur) == DATA_W);
    rx_sh_d    = in_rx ? ((rx_sh_q << 1) | DATA_W'(audio_DACDAT)) : rx_sh_q;
    rx_lhold_d = (slot_end && !bit_cnt_q[5]) ? rx_sh_d : rx_lhold_q;
    rx_done_d  = slot_end && bit_cnt_q[5];
    // The right word stays put in rx_sh_q until the next frame, so publish it one cycle later.
    rx_valid_d = rx_done_q;
    rx_left_d  = rx_done_q ? rx_lhold_q : rx_left_q;
    rx_right_d = rx_done_q ? rx_sh_q : rx_right_q;
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      div_cnt_q  <= '0;
      bclk_q     <= 1'b0;
      bit_cnt_q  <= 6'd63;
      lrck_q     <= 1'b0;
      adcdat_q   <= 1'b0;
      buf_l_q    <= '0;
      buf_r_q    <= '0;
      full_q     <= 1'b0;
      tx_ready_q <= 1'b1;
      tx_l_q     <= '0;
      tx_r_q     <= '0;
      underrun_q <= 1'b0;
      rx_sh_q    <= '0;
      rx_lhold_q <= '0;
      rx_done_q  <= 1'b0;
      rx_left_q  <= '0;
      rx_right_q <= '0;
      rx_valid_q <= 1'b0;
    end else begin
      div_cnt_q  <= div_cnt_d;
      bclk_q     <= bclk_d;
      bit_cnt_q  <= bit_cnt_d;
      lrck_q     <= lrck_d;
      adcdat_q   <= adcdat_d;
      buf_l_q    <= buf_l_d;
      buf_r_q    <= buf_r_d;
      full_q     <= full_d;
      tx_ready_q <= tx_ready_d;
      tx_l_q     <= tx_l_d;
      tx_r_q     <= tx_r_d;
      underrun_q <= underrun_d;
      rx_sh_q    <= rx_sh_d;
      rx_lhold_q <= rx_lhold_d;
      rx_done_q  <= rx_done_d;
      rx_left_q  <= rx_left_d;
      rx_right_q <= rx_right_d;
      rx_valid_q <= rx_valid_d;
    end
  end

  assign tx_ready      = tx_ready_q;
  assign rx_left       = rx_left_q;
  assign rx_right      = rx_right_q;
  assign rx_valid      = rx_valid_q;
  assign audio_BCLK    = bclk_q;
  assign audio_ADCLRCK = lrck_q;
  assign audio_DACLRCK = lrck_q;
  assign audio_ADCDAT  = adcdat_q;
  assign underrun      = underrun_q;
endmodule

// File: tb/tb_audio_codec_emulator.sv
// tb/tb_audio_codec_emulator.sv - directed bench for audio_codec_emulator
// u0 is the default 16-bit build, u1 the 24-bit build; both loop ADCDAT back into DACDAT.
module tb_audio_codec_emulator;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [15:0] txl0 = '0, txr0 = '0, rxl0, rxr0;
  logic        txv0 = 1'b0, rdy0, rxv0, bclk0, alr0, dlr0, adc0, und0;
  logic [23:0] txl1 = '0, txr1 = '0, rxl1, rxr1;
  logic        txv1 = 1'b0, rdy1, rxv1, bclk1, alr1, dlr1, adc1, und1;

  always #5 clk = ~clk;

  audio_codec_emulator u0 (
    .clk_clk(clk), .reset_reset_n(rst_n),
    .tx_left(txl0), .tx_right(txr0), .tx_valid(txv0), .tx_ready(rdy0),
    .rx_left(rxl0), .rx_right(rxr0), .rx_valid(rxv0),
    .audio_BCLK(bclk0), .audio_ADCLRCK(alr0), .audio_DACLRCK(dlr0),
    .audio_ADCDAT(adc0), .audio_DACDAT(adc0), .underrun(und0)
  );

  audio_codec_emulator #(.DATA_W(24), .BCLK_DIV(4)) u1 (
    .clk_clk(clk), .reset_reset_n(rst_n),
    .tx_left(txl1), .tx_right(txr1), .tx_valid(txv1), .tx_ready(rdy1),
    .rx_left(rxl1), .rx_right(rxr1), .rx_valid(rxv1),
    .audio_BCLK(bclk1), .audio_ADCLRCK(alr1), .audio_DACLRCK(dlr1),
    .audio_ADCDAT(adc1), .audio_DACDAT(adc1), .underrun(und1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_frame(input bit sel, output bit ok);
    bit prev;
    prev = sel ? alr1 : alr0;
    ok = 1'b0;
    for (int i = 0; i < 700; i++) begin
      tick();
      if (prev && !(sel ? alr1 : alr0)) begin
        ok = 1'b1;
        break;
      end
      prev = sel ? alr1 : alr0;
    end
  endtask

  task automatic wait_rxv(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 700; i++) begin
      tick();
      if (rxv0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Call right after a frame-start edge: bit b of the frame is sampled mid-bit at offset 8b+3.
  task automatic capture(input bit sel, output logic [31:0] sl, output logic [31:0] sr,
                         output int nrx, output logic [31:0] rl, output logic [31:0] rr);
    logic a;
    sl = '0; sr = '0; nrx = 0; rl = '0; rr = '0;
    for (int i = 0; i < 510; i++) begin
      tick();
      a = sel ? adc1 : adc0;
      if (i % 8 == 3) begin
        if (i < 256) sl = {sl[30:0], a};
        else         sr = {sr[30:0], a};
      end
      if (sel ? rxv1 : rxv0) begin
        nrx++;
        rl = sel ? 32'(rxl1) : 32'(rxl0);
        rr = sel ? 32'(rxr1) : 32'(rxr0);
      end
    end
  endtask

  task automatic release_and_check(input string tag);
    int nrx;
    nrx = 0;
    rst_n = 1'b1;
    cyc = 0;
    repeat (3) begin tick(); if (rxv0) nrx++; end
    check({tag, "_bclk_e3"}, bclk0, 1'b0);
    tick();
    check({tag, "_bclk_e4"}, bclk0, 1'b1);
    repeat (3) begin tick(); if (rxv0) nrx++; end
    check({tag, "_bclk_e7"}, bclk0, 1'b1);
    tick();
    check({tag, "_bclk_e8"}, bclk0, 1'b0);
    check({tag, "_und_e8"}, und0, 1'b1);
    check({tag, "_lrck_e8"}, alr0, 1'b0);
    tick();
    check({tag, "_und_e9"}, und0, 1'b0);
    check({tag, "_no_rxv"}, nrx, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int und_c0, und_c1, bad_adc, lr_mis, low;
    int br1, br2, lr1, lr2;
    bit pb, pl;
    logic [31:0] sl, sr, rl, rr;
    int nrx;

    repeat (3) tick();
    check("rst_bclk", bclk0, 1'b0);
    check("rst_lrck", {alr0, dlr0, alr1}, 3'b000);
    check("rst_adc", {adc0, adc1}, 2'b00);
    check("rst_rx", {rxl0, rxr0}, 32'h0);
    check("rst_rxv_und", {rxv0, und0}, 2'b00);
    check("rst_ready", {rdy0, rdy1}, 2'b11);

    release_and_check("boot");

    und_c0 = 0; und_c1 = 0; bad_adc = 0; lr_mis = 0;
    br1 = -1; br2 = -1; lr1 = -1; lr2 = -1;
    pb = bclk0; pl = alr0;
    for (int i = 0; i < 1024; i++) begin
      tick();
      if (und0) und_c0++;
      if (und1) und_c1++;
      if (adc0 || adc1) bad_adc++;
      if (alr0 !== dlr0 || alr1 !== dlr1) lr_mis++;
      if (!pb && bclk0) begin
        if (br1 < 0) br1 = cyc; else if (br2 < 0) br2 = cyc;
      end
      if (!pl && alr0) begin
        if (lr1 < 0) lr1 = cyc; else if (lr2 < 0) lr2 = cyc;
      end
      pb = bclk0; pl = alr0;
    end
    check("idle_underruns0", und_c0, 2);
    check("idle_underruns1", und_c1, 2);
    check("idle_adcdat", bad_adc, 0);
    check("idle_lrck_pair", lr_mis, 0);
    check("idle_bclk_period", br2 - br1, 8);
    check("idle_lrck_rise", lr1, 264);
    check("idle_lrck_period", lr2 - lr1, 512);

    txl0 = 16'hA5C3; txr0 = 16'h5A3C; txv0 = 1'b1;
    tick();
    txv0 = 1'b0;
    check("lb_ready_low", rdy0, 1'b0);
    wait_frame(1'b0, ok);
    check("lb_frame_to", ok, 1'b1);
    check("lb_no_underrun", und0, 1'b0);
    check("lb_ready_back", rdy0, 1'b1);
    capture(1'b0, sl, sr, nrx, rl, rr);
    check("lb_slot_l", sl, {1'b0, 16'hA5C3, 15'h0});
    check("lb_slot_r", sr, {1'b0, 16'h5A3C, 15'h0});
    check("lb_nrx", nrx, 1);
    check("lb_rx_l", rl, 32'h0000A5C3);
    check("lb_rx_r", rr, 32'h00005A3C);

    wait_frame(1'b0, ok);
    check("bp_frame_to", ok, 1'b1);
    repeat (100) tick();
    txl0 = 16'h1111; txr0 = 16'h2222; txv0 = 1'b1;
    tick();
    check("bp_ready_low", rdy0, 1'b0);
    txl0 = 16'h3333; txr0 = 16'h4444;
    low = 0;
    while (!rdy0 && low < 1000) begin
      tick();
      low++;
    end
    check("bp_low_cycles", low, 411);
    check("bp_no_underrun", und0, 1'b0);
    check("bp_at_frame_start", alr0, 1'b0);
    tick();
    check("bp_second_accept", rdy0, 1'b0);
    txv0 = 1'b0;
    wait_rxv(ok);
    check("bp_rxv1_to", ok, 1'b1);
    check("bp_rx_a", {rxl0, rxr0}, 32'h11112222);
    wait_rxv(ok);
    check("bp_rxv2_to", ok, 1'b1);
    check("bp_rx_b", {rxl0, rxr0}, 32'h33334444);

    wait_frame(1'b0, ok);
    check("col_frame_to", ok, 1'b1);
    repeat (511) tick();
    txl0 = 16'h1234; txr0 = 16'hFEDC; txv0 = 1'b1;
    tick();
    txv0 = 1'b0;
    check("col_lrck_fell", alr0, 1'b0);
    check("col_underrun", und0, 1'b1);
    check("col_accepted", rdy0, 1'b0);
    capture(1'b0, sl, sr, nrx, rl, rr);
    check("col_zero_slots", {sl | sr}, 32'h0);
    check("col_nrx", nrx, 1);
    check("col_rx_zero", rl | rr, 32'h0);
    wait_frame(1'b0, ok);
    check("col2_frame_to", ok, 1'b1);
    check("col2_no_underrun", und0, 1'b0);
    capture(1'b0, sl, sr, nrx, rl, rr);
    check("col2_slot_l", sl, {1'b0, 16'h1234, 15'h0});
    check("col2_slot_r", sr, {1'b0, 16'hFEDC, 15'h0});
    check("col2_rx", {rl[15:0], rr[15:0]}, 32'h1234FEDC);

    wait_frame(1'b0, ok);
    check("mr_frame_to", ok, 1'b1);
    tick();
    txl0 = 16'hBEEF; txr0 = 16'hCAFE; txv0 = 1'b1;
    tick();
    txv0 = 1'b0;
    check("mr_buffer_full", rdy0, 1'b0);
    repeat (164) tick();
    check("mr_pre_bclk", bclk0, 1'b1);
    check("mr_pre_rx_l", rxl0, 16'h1234);
    rst_n = 1'b0;
    #1;
    check("mr_bclk", bclk0, 1'b0);
    check("mr_lrck", {alr0, dlr0}, 2'b00);
    check("mr_adc", adc0, 1'b0);
    check("mr_rx", {rxl0, rxr0}, 32'h0);
    check("mr_rxv_und", {rxv0, und0}, 2'b00);
    check("mr_ready", rdy0, 1'b1);
    tick();
    tick();
    release_and_check("mr");

    txl1 = 24'h800001; txr1 = 24'h7FFFFE; txv1 = 1'b1;
    tick();
    txv1 = 1'b0;
    check("w24_ready_low", rdy1, 1'b0);
    wait_frame(1'b1, ok);
    check("w24_frame_to", ok, 1'b1);
    check("w24_no_underrun", und1, 1'b0);
    capture(1'b1, sl, sr, nrx, rl, rr);
    check("w24_slot_l", sl, {1'b0, 24'h800001, 7'h0});
    check("w24_slot_r", sr, {1'b0, 24'h7FFFFE, 7'h0});
    check("w24_nrx", nrx, 1);
    check("w24_rx_l", rl, 32'h00800001);
    check("w24_rx_r", rr, 32'h007FFFFE);

    wait_rxv(ok);
    check("mr_discard_rxv_to", ok, 1'b1);
    check("mr_discard_rx", {rxl0, rxr0}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
